// File: rtl/serial_adder_seq.sv
// ---------------------------------------------------------------------------
// serial_adder_seq
// Bit-serial adder. An operand pair is accepted through a valid/ready
// handshake, added one bit pair per clock (LSB first) over exactly WIDTH
// cycles, and the (WIDTH+1)-bit result {cout,sum} is offered through a
// second valid/ready handshake. The pipeline holds one operation at a time.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand pair on a/b is valid
//   in_ready   : block accepts an operand pair this cycle (IDLE only)
//   a, b       : operands, WIDTH bits each
//   out_valid  : sum/cout hold a completed result (DONE only)
//   out_ready  : consumer takes the result this cycle
//   sum        : (a+b) mod 2^WIDTH
//   cout       : carry out of bit WIDTH-1
//   busy       : high while the serial add is running
// ---------------------------------------------------------------------------
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Counter reaches WIDTH at most, so it never wraps.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Holds the WIDTH-1 result bits produced before the final one; the final
    // bit is concatenated on top when the result moves to sum.
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [1:0]       w_ha1;
    logic [1:0]       w_ha2;
    logic             w_s;
    logic             w_c_next;
    logic [WIDTH-1:0] w_sum_full;
    logic             w_last;
    logic             w_accept;
    logic             w_deliver;

    // Half adder: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full-add of the current bit pair from two half-add steps, plus the
    // shifted result word and the last-bit detect.
    always_comb begin
        w_ha1      = half_add(r_a[0], r_b[0]);
        w_ha2      = half_add(w_ha1[0], r_carry);
        w_s        = w_ha2[0];
        w_c_next   = w_ha1[1] | w_ha2[1];
        w_sum_full = {w_s, r_res};
        w_last     = (r_cnt == CW'(WIDTH - 1));
        w_accept   = in_valid & r_in_ready;
        w_deliver  = r_out_valid & out_ready;
    end

    // Next-state logic of the IDLE -> RUN -> DONE control FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (w_deliver) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register and registered handshake/status flags decoded from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
            r_busy      <= (w_state_next == RUN);
        end
    end

    // Datapath: operand capture, one bit per RUN cycle, result transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= w_sum_full[WIDTH-1:1];
                    r_carry <= w_c_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum  <= w_sum_full;
                        r_cout <= w_c_next;
                    end
                end
                default: begin
                    // DONE: sum/cout hold until delivered
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: doc/serial_adder_seq.md
SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair on a/b is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port out_valid, output, 1 bit: sum/cout hold a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result, (a+b) mod 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the block is in state RUN.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-015 Accept SHALL occur when in_valid && in_ready at a rising edge, with these effects:
- capture a and b into shift registers;
- clear the carry register and the bit counter;
- go to RUN.
REQ-016 Each RUN cycle SHALL process one bit pair, LSB first, as a full add built from two half-add steps:
- s = a0 ^ b0 ^ c;
- c_next = (a0 & b0) | ((a0 ^ b0) & c).
REQ-017 Each RUN cycle SHALL also:
- shift s into the result register from the MSB end, shifting right;
- shift both operand registers right by one;
- increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the block SHALL:
- write c_next to cout;
- move the result to sum;
- go to DONE.
REQ-019 Latency SHALL be fixed: if accept happens at edge k, out_valid SHALL first be 1 after edge k+WIDTH.
REQ-020 In DONE, out_valid SHALL be 1, and sum and cout SHALL hold stable for as long as out_ready is 0.
REQ-021 When out_valid && out_ready at an edge, the block SHALL go to IDLE and drive out_valid to 0 after that edge. There is no same-cycle re-accept; the next accept can occur at the following edge at the earliest.
REQ-022 While in RUN or DONE, in_valid, a and b SHALL be ignored, and no operand is lost, because in_ready is 0.
REQ-023 In IDLE, sum and cout SHALL keep the last delivered result; only out_valid qualifies them.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide, and it SHALL neither wrap nor be used outside RUN.
REQ-025 The output widths SHALL be fixed: the full result is {cout,sum} = a+b, which is WIDTH+1 bits and never truncated.

Reset
REQ-026 With rst=1 at an edge, the block SHALL set the following regardless of current state, including mid-RUN and DONE:
- state to IDLE;
- out_valid to 0, busy to 0 and in_ready to 1;
- sum, cout, the carry register, the counter and the operand registers to 0.
REQ-027 rst SHALL take priority over accept and over the output handshake in the same cycle; an in-flight operation is discarded, not completed.
REQ-028 After rst is released, the first accept SHALL be possible at the first edge with in_valid=1.

Verification
REQ-029 Accept a=8'hFF, b=8'h01 -> out_valid=1 exactly 8 cycles after accept, with sum=8'h00 and cout=1.
REQ-030 Accept a=8'hA5, b=8'h5A -> sum=8'hFF and cout=0; busy is high for 8 cycles, then low.
REQ-031 Accept a=8'h80, b=8'h80 with out_ready held 0 for 5 cycles after out_valid -> sum=8'h00 and cout=1 stay stable throughout; out_valid drops 1 cycle after out_ready=1.
REQ-032 Toggle in_valid with new a/b during RUN and DONE -> in_ready stays 0 and the result matches the first accepted pair only.
REQ-033 Assert rst=1 on the 4th RUN cycle of a=8'h0F, b=8'h01 -> next cycle shows IDLE, out_valid=0, in_ready=1, sum=0, cout=0; then accepting 8'h03+8'h04 gives sum=8'h07, cout=0.
REQ-034 Run back-to-back pairs with out_ready=1 and in_valid=1 constantly -> one result every WIDTH+2 cycles; compare 200 random pairs against a+b.
